// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, ExcCodes and Status/Cause bit positions
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LSB = 8;
  localparam int ST_BEV    = 22;

  // BEV set out of reset; only IM, EXL and IE are software-writable
  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  localparam int CA_EXC_LSB = 2;
  localparam int CA_IP_LSB  = 8;
  localparam int CA_TI      = 30;
  localparam int CA_BD      = 31;

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with prescaler and sticky timer interrupt
module cp0_timer #(
  parameter int WIDTH     = 32,
  parameter int COUNT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_we,
  input  logic             cmp_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] compare,
  output logic             ti
);

  logic [3:0]       presc_q;
  logic             tick;
  logic [WIDTH-1:0] count_next;

  assign tick = (presc_q == 4'(COUNT_DIV - 1));

  always_comb begin
    count_next = count;
    if (cnt_we)
      count_next = wdata;
    else if (tick)
      count_next = count + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      count   <= count_next;
      presc_q <= (cnt_we || tick) ? 4'd0 : presc_q + 4'd1;
      if (cmp_we)
        compare <= wdata;
      // a Compare write acknowledges the interrupt even if the match recurs this cycle
      if (cmp_we)
        ti <= 1'b0;
      else if (count_next == compare)
        ti <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// rtl/cp0_exc_unit.sv - MIPS32 CP0: register file, exception entry/ERET, interrupt pending
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               HW_INT     = 6,
  parameter int               COUNT_DIV  = 2,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [WIDTH-1:0] PRID_VAL   = 32'h0000_4220,
  parameter logic [WIDTH-1:0] CONFIG_RST = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mtc0_we,
  input  logic [4:0]        waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [4:0]        raddr,
  output logic [WIDTH-1:0]  rdata,
  input  logic [HW_INT-1:0] hw_int,
  input  logic              exc_valid,
  input  logic [4:0]        exc_code,
  input  logic [WIDTH-1:0]  exc_pc,
  input  logic              exc_bd,
  input  logic              exc_badv_we,
  input  logic [WIDTH-1:0]  exc_badvaddr,
  input  logic              eret,
  output logic [WIDTH-1:0]  exc_vector,
  output logic [WIDTH-1:0]  epc_out,
  output logic              int_pending,
  output logic              timer_int,
  output logic              kernel_mode
);

  localparam logic [WIDTH-1:0] ST_RST  = WIDTH'(STATUS_RST);
  localparam logic [WIDTH-1:0] ST_MASK = WIDTH'(STATUS_WMASK);

  logic [WIDTH-1:0] status_q, epc_q, badvaddr_q, config_q, count, compare, cause_val;
  logic [4:0]       exc_code_q;
  logic [1:0]       ip_sw_q;
  logic [5:0]       ip_hw_q, hw_pad;
  logic [7:0]       cause_ip;
  logic             bd_q, ti, exl, wr_en, status_wr;

  assign exl       = status_q[ST_EXL];
  assign wr_en     = mtc0_we & ~exc_valid;
  assign status_wr = wr_en & ~eret & (waddr == REG_STATUS);

  cp0_timer #(.WIDTH(WIDTH), .COUNT_DIV(COUNT_DIV)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .cnt_we  (wr_en & (waddr == REG_COUNT)),
    .cmp_we  (wr_en & (waddr == REG_COMPARE)),
    .wdata   (wdata),
    .count   (count),
    .compare (compare),
    .ti      (ti)
  );

  always_comb begin
    hw_pad = '0;
    hw_pad[HW_INT-1:0] = hw_int;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q   <= ST_RST;
      epc_q      <= '0;
      badvaddr_q <= '0;
      config_q   <= CONFIG_RST;
      exc_code_q <= '0;
      bd_q       <= 1'b0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
    end else begin
      ip_hw_q <= hw_pad;
      if (exc_valid) begin
        status_q[ST_EXL] <= 1'b1;
        exc_code_q       <= exc_code;
        // nested exceptions keep the original return point
        if (!exl) begin
          epc_q <= exc_bd ? exc_pc - WIDTH'(4) : exc_pc;
          bd_q  <= exc_bd;
        end
        if (exc_badv_we)
          badvaddr_q <= exc_badvaddr;
      end else begin
        if (eret)
          status_q[ST_EXL] <= 1'b0;
        else if (status_wr)
          status_q <= (status_q & ~ST_MASK) | (wdata & ST_MASK);
        if (wr_en && waddr == REG_EPC)
          epc_q <= wdata;
        if (wr_en && waddr == REG_CAUSE)
          ip_sw_q <= wdata[9:8];
      end
    end
  end

  assign cause_ip = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};

  always_comb begin
    cause_val = '0;
    cause_val[CA_BD]             = bd_q;
    cause_val[CA_TI]             = ti;
    cause_val[CA_IP_LSB +: 8]    = cause_ip;
    cause_val[CA_EXC_LSB +: 5]   = exc_code_q;
  end

  always_comb begin
    case (raddr)
      REG_BADVADDR: rdata = badvaddr_q;
      REG_COUNT:    rdata = count;
      REG_COMPARE:  rdata = compare;
      REG_STATUS:   rdata = status_q;
      REG_CAUSE:    rdata = cause_val;
      REG_EPC:      rdata = epc_q;
      REG_PRID:     rdata = PRID_VAL;
      REG_CONFIG:   rdata = config_q;
      default:      rdata = '0;
    endcase
  end

  assign exc_vector  = EXC_VECTOR;
  assign epc_out     = epc_q;
  assign timer_int   = ti;
  assign kernel_mode = exl;
  assign int_pending = status_q[ST_IE] & ~exl & |(cause_ip & status_q[ST_IM_LSB +: 8]);

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb/tb_cp0_exc_unit.sv - self-checking bench for cp0_exc_unit
module tb_cp0_exc_unit;

  logic        clk, rst, mtc0_we, exc_valid, exc_bd, exc_badv_we, eret;
  logic [4:0]  waddr, raddr, exc_code;
  logic [31:0] wdata, exc_pc, exc_badvaddr;
  logic [5:0]  hw_int;
  logic [31:0] rdata, exc_vector, epc_out, rdata1, exc_vector1, epc_out1;
  logic        int_pending, timer_int, kernel_mode, int_pending1, timer_int1, kernel_mode1;

  cp0_exc_unit dut (
    .clk(clk), .rst(rst), .mtc0_we(mtc0_we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .hw_int(hw_int), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd), .exc_badv_we(exc_badv_we),
    .exc_badvaddr(exc_badvaddr), .eret(eret), .exc_vector(exc_vector),
    .epc_out(epc_out), .int_pending(int_pending), .timer_int(timer_int),
    .kernel_mode(kernel_mode)
  );

  cp0_exc_unit #(.COUNT_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .mtc0_we(mtc0_we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata1), .hw_int(hw_int), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd), .exc_badv_we(exc_badv_we),
    .exc_badvaddr(exc_badvaddr), .eret(eret), .exc_vector(exc_vector1),
    .epc_out(epc_out1), .int_pending(int_pending1), .timer_int(timer_int1),
    .kernel_mode(kernel_mode1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string       name;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[12];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic expect_v(input string n, input logic [31:0] e);
    sb_t s;
    s.name = n;
    s.exp  = e;
    sb_q.push_back(s);
  endtask

  task automatic check_v(input logic [31:0] a);
    sb_t s;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty actual=%h", a);
    end else begin
      s = sb_q.pop_front();
      if (a !== s.exp) begin
        n_fail++;
        $display("FAIL %s actual=%h expected=%h", s.name, a, s.exp);
      end
    end
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    expect_v(n, e);
    check_v(a);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1'b1;
    waddr   = a;
    wdata   = d;
    step();
    mtc0_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    raddr = a;
    #1;
    v = rdata;
  endtask

  task automatic take_exc(input logic [31:0] pc, input logic bd, input logic [4:0] code,
                          input logic bwe, input logic [31:0] bva);
    exc_valid    = 1'b1;
    exc_pc       = pc;
    exc_bd       = bd;
    exc_code     = code;
    exc_badv_we  = bwe;
    exc_badvaddr = bva;
    step();
    exc_valid   = 1'b0;
    exc_badv_we = 1'b0;
    exc_bd      = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    vecs[0]  = '{"wr_compare",   5'd11, 32'h0000_1000, 5'd11, 32'h0000_1000};
    vecs[1]  = '{"wr_status_all",5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0040_FF03};
    vecs[2]  = '{"wr_status_0",  5'd12, 32'h0000_0000, 5'd12, 32'h0040_0000};
    vecs[3]  = '{"wr_epc",       5'd14, 32'hDEAD_BEEF, 5'd14, 32'hDEAD_BEEF};
    vecs[4]  = '{"wr_cause_all", 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0300};
    vecs[5]  = '{"wr_cause_0",   5'd13, 32'h0000_0000, 5'd13, 32'h0000_0000};
    vecs[6]  = '{"wr_count",     5'd9,  32'h0000_0100, 5'd9,  32'h0000_0100};
    vecs[7]  = '{"wr_badvaddr",  5'd8,  32'h1234_5678, 5'd8,  32'h0000_0000};
    vecs[8]  = '{"wr_prid",      5'd15, 32'h0000_0000, 5'd15, 32'h0000_4220};
    vecs[9]  = '{"wr_config",    5'd16, 32'h0000_0000, 5'd16, 32'h8000_0000};
    vecs[10] = '{"rd_reg3",      5'd3,  32'h0000_FFFF, 5'd3,  32'h0000_0000};
    vecs[11] = '{"wr_compare2",  5'd11, 32'h0000_ABCD, 5'd11, 32'h0000_ABCD};

    rst = 1'b0; mtc0_we = 1'b0; waddr = '0; wdata = '0; raddr = 5'd12;
    hw_int = '0; exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
    exc_badv_we = 1'b0; exc_badvaddr = '0; eret = 1'b0;
    step(2);
    chk("rst_status", rdata, 32'h0040_0000);
    chk("rst_timer_int", {31'd0, timer_int}, 32'd0);
    chk("rst_kernel", {31'd0, kernel_mode}, 32'd0);
    chk("rst_int_pending", {31'd0, int_pending}, 32'd0);
    chk("exc_vector", exc_vector, 32'hBFC0_0380);
    rst = 1'b1;
    step();

    foreach (vecs[i]) begin
      mtc0(vecs[i].waddr, vecs[i].wdata);
      expect_v(vecs[i].name, vecs[i].exp);
      rd(vecs[i].raddr, v);
      check_v(v);
    end

    // write visible only after the edge
    raddr = 5'd14; mtc0_we = 1'b1; waddr = 5'd14; wdata = 32'h5555_5555;
    #1;
    chk("epc_no_bypass", rdata, 32'hDEAD_BEEF);
    step();
    mtc0_we = 1'b0;
    chk("epc_after_edge", rdata, 32'h5555_5555);

    // timer with COUNT_DIV=2
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    step(9);
    rd(5'd9, v);
    chk("count_9clk", v, 32'd4);
    chk("ti_before_match", {31'd0, timer_int}, 32'd0);
    step();
    rd(5'd9, v);
    chk("count_10clk", v, 32'd5);
    chk("ti_at_match", {31'd0, timer_int}, 32'd1);
    rd(5'd13, v);
    chk("cause_ti_ip7", v, 32'h4000_8000);
    mtc0(5'd11, 32'd9);
    chk("ti_cleared", {31'd0, timer_int}, 32'd0);

    // interrupt pending
    mtc0(5'd11, 32'hFFFF_0000);
    mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'b000001;
    #1;
    chk("int_same_cycle", {31'd0, int_pending}, 32'd0);
    step();
    chk("int_one_later", {31'd0, int_pending}, 32'd1);
    mtc0(5'd12, 32'h0000_0403);
    chk("int_masked_exl", {31'd0, int_pending}, 32'd0);
    chk("kernel_by_mtc0", {31'd0, kernel_mode}, 32'd1);
    eret = 1'b1;
    step();
    eret = 1'b0;
    chk("eret_kernel", {31'd0, kernel_mode}, 32'd0);
    chk("int_after_eret", {31'd0, int_pending}, 32'd1);
    hw_int = '0;
    mtc0(5'd12, 32'd0);

    // exception entry, delay slot, nested
    take_exc(32'h8000_0104, 1'b1, 5'd12, 1'b1, 32'h0000_1111);
    chk("epc_bd", epc_out, 32'h8000_0100);
    rd(5'd13, v);
    chk("cause_bd_ov", v, 32'h8000_0030);
    chk("exc_kernel", {31'd0, kernel_mode}, 32'd1);
    rd(5'd8, v);
    chk("badvaddr_load", v, 32'h0000_1111);
    take_exc(32'h8000_0200, 1'b0, 5'd4, 1'b0, 32'h0000_2222);
    chk("epc_nested", epc_out, 32'h8000_0100);
    rd(5'd13, v);
    chk("cause_nested", v, 32'h8000_0010);
    rd(5'd8, v);
    chk("badvaddr_kept", v, 32'h0000_1111);
    eret = 1'b1;
    step();
    eret = 1'b0;

    // exc_valid beats eret and MTC0 in one cycle
    eret = 1'b1; mtc0_we = 1'b1; waddr = 5'd14; wdata = 32'h0000_1234;
    take_exc(32'h8000_0300, 1'b0, 5'd8, 1'b0, 32'd0);
    eret = 1'b0; mtc0_we = 1'b0;
    chk("prio_kernel", {31'd0, kernel_mode}, 32'd1);
    chk("prio_epc", epc_out, 32'h8000_0300);
    eret = 1'b1;
    step();
    eret = 1'b0;
    chk("eret_alone", {31'd0, kernel_mode}, 32'd0);
    eret = 1'b1;
    mtc0(5'd12, 32'h0000_0003);
    eret = 1'b0;
    rd(5'd12, v);
    chk("eret_blocks_status", v, 32'h0040_0000);

    // Count wrap with COUNT_DIV=1 instance
    raddr = 5'd9;
    mtc0(5'd9, 32'hFFFF_FFFF);
    chk("count_loaded", rdata1, 32'hFFFF_FFFF);
    step();
    chk("count_wrap", rdata1, 32'h0000_0000);

    // asynchronous reset in the middle of a run
    mtc0(5'd11, 32'h20);
    mtc0(5'd9, 32'h1F);
    step(2);
    chk("ti_pre_reset", {31'd0, timer_int}, 32'd1);
    raddr = 5'd12;
    take_exc(32'h8000_0400, 1'b0, 5'd9, 1'b0, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_status", rdata, 32'h0040_0000);
    chk("mid_rst_ti", {31'd0, timer_int}, 32'd0);
    chk("mid_rst_kernel", {31'd0, kernel_mode}, 32'd0);
    chk("mid_rst_epc", epc_out, 32'd0);
    chk("mid_rst_int", {31'd0, int_pending}, 32'd0);
    step();
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
